// File: rtl/disp_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Each digit slot opens with a guard interval (all anodes off) to suppress ghosting.
module disp_scan_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GEND = PW'(BLANK_CYC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(N_DIGITS - 1);

  typedef enum logic {GUARD, SHOW} state_t;

  logic [N_DIGITS-1:0][3:0] shadow;
  logic [PW-1:0]            p;
  logic                     run;
  logic [DW-1:0]            d, d_nx;
  state_t                   state, state_nx;
  logic [3:0]               nib_nx;
  logic [N_DIGITS-1:0]      an_nx, dsel, upper_zero;
  logic                     fd_nx, blank, acc;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_sel
    assign dsel[i] = (d == DW'(i));
  end

  // upper_zero[i]: shadow digits i..N_DIGITS-1 are all zero
  always_comb begin
    upper_zero = '0;
    acc        = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc           = acc & (shadow[i] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  assign blank = lz_en && (d != '0) && |(upper_zero & dsel);

  always_comb begin
    state_nx = state;
    nib_nx   = nibble;
    an_nx    = an_n;
    d_nx     = d;
    fd_nx    = 1'b0;
    case (state)
      GUARD: begin
        an_nx = '1;
        // run gates the first cycle after reset, where p is still 0 but not yet counting
        if (run && p == P_GEND) begin
          state_nx = SHOW;
          nib_nx   = shadow[d];
          an_nx    = blank ? '1 : ~dsel;
        end
      end
      SHOW: begin
        if (p == P_LAST) begin
          state_nx = GUARD;
          an_nx    = '1;
          d_nx     = (d == D_LAST) ? '0 : d + 1'b1;
          fd_nx    = (d == D_LAST);
        end
      end
      default: state_nx = GUARD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      p          <= '0;
      run        <= 1'b0;
      d          <= '0;
      state      <= GUARD;
      nibble     <= 4'h0;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      run <= 1'b1;
      if (!run || p == P_LAST) p <= '0;
      else                     p <= p + 1'b1;
      if (load) shadow <= value;
      state      <= state_nx;
      d          <= d_nx;
      nibble     <= nib_nx;
      an_n       <= an_nx;
      frame_done <= fd_nx;
    end
  end

endmodule

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
- Latches a packed hex value and presents one 4-bit digit at a time on a registered nibble bus, which feeds the hex-to-7-segment decoder directly.
- Drives the active-low digit enables in step with the nibble.
- Provides a ghosting guard interval, optional leading-zero blanking and a frame strobe.

Parameters:
- N_DIGITS, 4, number of display digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYC+2).
- BLANK_CYC, 16, guard cycles at the start of each slot with all anodes off (>= 1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*N_DIGITS  packed hex value; digit i = value[4i+3:4i], digit 0 least significant.
- load  in  1  capture value into shadow register.
- lz_en  in  1  leading-zero blanking enable.
- nibble  out  4  hex digit for the decoder (registered).
- an_n  out  N_DIGITS  active-low digit enables; an_n[i] drives digit i (registered).
- frame_done  out  1  one-cycle pulse at end of the last digit slot.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any cycle, including mid-slot): shadow=0, prescaler p=0, digit index d=0, state=GUARD, nibble=0, an_n=all ones, frame_done=0. Reset takes effect at the next edge.
- Edge numbering: edge 1 is the first rising edge with rst low.
- Prescaler p:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Edge k after reset sets p=(k-1) mod REFRESH_DIV. For example, with REFRESH_DIV=8, edge 1 sets p=0, edge 8 sets p=7, edge 9 sets p=0.
- FSM, two states:
  - GUARD: an_n=all ones. When p==BLANK_CYC-1, the next edge enters SHOW, selects digit d, loads nibble=shadow digit d, and drives an_n[d]=0 unless the digit is blanked. All other anodes stay 1.
  - SHOW: nibble and an_n are held constant. When p==REFRESH_DIV-1, the next edge enters GUARD, sets an_n=all ones, and advances d=(d==N_DIGITS-1)?0:d+1. nibble holds its last value.
- Timing: digit i is lit after edges i*REFRESH_DIV+BLANK_CYC+1 through (i+1)*REFRESH_DIV of each frame. At most one anode is ever low.
- frame_done:
  - High for exactly the one cycle following the edge where d wraps from N_DIGITS-1 to 0.
  - The first pulse appears after edge N_DIGITS*REFRESH_DIV+1.
- Shadow register:
  - Captured on any edge with load=1.
  - The nibble is sampled from shadow only on the GUARD->SHOW edge. A load during SHOW never changes the digit currently lit; it takes effect from the next slot.
  - If load coincides with the GUARD->SHOW edge, the nibble uses the old shadow.
- Leading-zero blanking:
  - With lz_en=1, digit d>0 is blanked (its anode stays 1 through SHOW) if shadow digits d..N_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - The blank decision is taken on the GUARD->SHOW edge, together with the nibble.
  - With lz_en=0, all digits are lit.
- value changes without load have no effect.

Test Plan (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2):
1. Reset: hold rst 3 cycles -> an_n=1111, nibble=0, frame_done=0. Release with value=16'h1234, load=1 on edge 1 -> an_n=1111 after edges 1-2; an_n=1110, nibble=4 after edge 3 through edge 8; an_n=1111 after edges 9-10; an_n=1101, nibble=3 after edge 11.
2. Full frame: continue from scenario 1 -> digits 4,3,2,1 appear on an_n 1110,1101,1011,0111 respectively. frame_done=1 only after edge 33. The pattern repeats with period 32.
3. Leading-zero blanking: load 16'h0050 with lz_en=1 -> digits 0 (0) and 1 (5) lit; an_n stays 1111 through the slots of digits 2 and 3. Same value with lz_en=0 -> 0,5,0,0 all lit. Load 16'h0000 with lz_en=1 -> only digit 0 lit, showing 0.
4. Load mid-SHOW: during digit 1's SHOW, load 16'hABCD over 16'h1234 -> nibble stays 3 until slot end; the next slot shows B on an_n=1011.
5. Reset mid-operation: assert rst during digit 2 SHOW -> after that edge an_n=1111, nibble=0; after release the sequence restarts at digit 0 with timing identical to scenario 1 and shadow=0.
6. Guard invariant: random load/value/lz_en over 2000 cycles -> an_n never has more than one 0 bit. an_n=all ones whenever p<BLANK_CYC. frame_done is never high for two consecutive cycles.
